// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard/forwarding control:
// forwarding select encodings, the XZR register index and the stall FSM states.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // XZR reads as zero and discards writes, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst == src) && (dst != XZR_IDX);
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand EX forwarding select: a non-load result in MEM wins over the
// WB value, otherwise the register-file bus is used.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       mem_mem2reg,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_sel
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data on the ALU-out bus yet, so it cannot forward.
  assign mem_hit = mem_regwrite && !mem_mem2reg && reg_match(mem_rd, ex_src);
  assign wb_hit  = wb_regwrite && reg_match(wb_rd, ex_src);

  always_comb begin
    fwd_sel = FWD_REG;
    if (mem_hit) begin
      fwd_sel = FWD_MEM;
    end else if (wb_hit) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/MEM/WB pipeline: load-use
// stalls, MEM-stage branch flushes, EX forwarding selects and event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_mem2reg,
  input  logic             mem_branch_taken,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] SCNT_LOAD  = 3'(STALL_CYCLES - 1);
  localparam logic       MULTI_STALL = (STALL_CYCLES > 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       scnt;
  logic [2:0]       scnt_nxt;
  logic             hz;
  logic             stall_act;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  assign hz = ex_memread && ex_regwrite && (ex_rd != XZR_IDX) &&
              ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  // The first stall cycle comes straight from hz in RUN; the rest are held
  // by the STALL state. A taken branch cancels the stall outright.
  assign stall_act = !mem_branch_taken && ((state == STALL) || hz);

  pipe_fwd_sel u_fwd_a (
    .ex_src       (ex_rn),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_mem2reg  (mem_mem2reg),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (fwd_a_sel)
  );

  pipe_fwd_sel u_fwd_b (
    .ex_src       (ex_rm),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_mem2reg  (mem_mem2reg),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (fwd_b_sel)
  );

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    if (mem_branch_taken) begin
      state_nxt = RUN;
      scnt_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (hz && MULTI_STALL) begin
            state_nxt = STALL;
            scnt_nxt  = SCNT_LOAD;
          end
        end
        STALL: begin
          scnt_nxt = scnt - 3'd1;
          if (scnt == 3'd1) begin
            state_nxt = RUN;
            scnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          scnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = 1'b0;
    fwd_a        = FWD_REG;
    fwd_b        = FWD_REG;
    if (reset) begin
      // Freeze the PC and hold every pipeline register cleared.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      pc_write     = !stall_act;
      if_id_write  = !stall_act;
      id_ex_bubble = stall_act;
      if_id_flush  = mem_branch_taken;
      id_ex_flush  = mem_branch_taken;
      ex_mem_flush = mem_branch_taken;
      pc_sel       = mem_branch_taken;
      fwd_a        = fwd_a_sel;
      fwd_b        = fwd_b_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (mem_branch_taken) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a single-cycle-stall instance and a
// three-cycle-stall instance with 4-bit counters share one set of inputs.
module tb_pipe_hazard_ctrl;

  localparam logic [10:0] O_RUN   = 11'b11_0_000_0_00_00;
  localparam logic [10:0] O_STALL = 11'b00_1_000_0_00_00;
  localparam logic [10:0] O_BR    = 11'b11_0_111_1_00_00;
  localparam logic [10:0] O_RST   = 11'b00_0_111_0_00_00;

  typedef struct {
    int id_rn; int id_rm; int uses;
    int ex_rn; int ex_rm; int ex_rd; int mr; int rw;
    int mem_rd; int mem_rw; int m2r;
    int br;
    int wb_rd; int wb_rw;
    logic [10:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rm, ex_memread, ex_regwrite, mem_regwrite, mem_mem2reg;
  logic       mem_branch_taken, wb_regwrite;

  logic        pc_write1, if_id_write1, id_ex_bubble1, if_id_flush1, id_ex_flush1, ex_mem_flush1, pc_sel1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [31:0] stall_count1, flush_count1;
  logic        pc_write3, if_id_write3, id_ex_bubble3, if_id_flush3, id_ex_flush3, ex_mem_flush3, pc_sel3;
  logic [1:0]  fwd_a3, fwd_b3;
  logic [3:0]  stall_count3, flush_count3;
  logic [10:0] o1, o3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign o1 = {pc_write1, if_id_write1, id_ex_bubble1, if_id_flush1, id_ex_flush1, ex_mem_flush1, pc_sel1, fwd_a1, fwd_b1};
  assign o3 = {pc_write3, if_id_write3, id_ex_bubble3, if_id_flush3, id_ex_flush3, ex_mem_flush3, pc_sel3, fwd_a3, fwd_b3};

  pipe_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) u_s1 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_mem2reg(mem_mem2reg), .mem_branch_taken(mem_branch_taken),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .id_ex_bubble(id_ex_bubble1),
    .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1),
    .pc_sel(pc_sel1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  pipe_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) u_s3 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_mem2reg(mem_mem2reg), .mem_branch_taken(mem_branch_taken),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write3), .if_id_write(if_id_write3), .id_ex_bubble(id_ex_bubble3),
    .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3), .ex_mem_flush(ex_mem_flush3),
    .pc_sel(pc_sel3), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
    .stall_count(stall_count3), .flush_count(flush_count3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rn = '0; id_rm = '0; id_uses_rm = 1'b0;
    ex_rn = '0; ex_rm = '0; ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_mem2reg = 1'b0; mem_branch_taken = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0;
  endtask

  // LDUR X2 in EX, ADD X3,X2,X4 in ID
  task automatic hazard();
    id_rn = 5'd2; id_rm = 5'd4; id_uses_rm = 1'b1;
    ex_rd = 5'd2; ex_memread = 1'b1; ex_regwrite = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    id_rn = 5'(v.id_rn); id_rm = 5'(v.id_rm); id_uses_rm = 1'(v.uses);
    ex_rn = 5'(v.ex_rn); ex_rm = 5'(v.ex_rm); ex_rd = 5'(v.ex_rd);
    ex_memread = 1'(v.mr); ex_regwrite = 1'(v.rw);
    mem_rd = 5'(v.mem_rd); mem_regwrite = 1'(v.mem_rw); mem_mem2reg = 1'(v.m2r);
    mem_branch_taken = 1'(v.br);
    wb_rd = 5'(v.wb_rd); wb_regwrite = 1'(v.wb_rw);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    chk({tag, "_out_s3"}, 32'(o3), 32'(O_RST));
    chk({tag, "_out_s1"}, 32'(o1), 32'(O_RST));
    chk({tag, "_stall_cnt"}, 32'(stall_count3), 32'd0);
    chk({tag, "_flush_cnt"}, 32'(flush_count3), 32'd0);
    @(posedge clk);
    #1;
    clear_in();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          id_rn rm us ex_rn rm rd mr rw mem_rd rw m2r br wb_rd rw  expected
    tbl[0]  = '{0,  0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0, O_RUN};
    tbl[1]  = '{2,  4,  1, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0,  0, O_STALL};
    tbl[2]  = '{3,  2,  1, 0, 0,  2,  1, 1, 0,  0, 0, 0, 0,  0, O_STALL};
    tbl[3]  = '{3,  2,  0, 0, 0,  2,  1, 1, 0,  0, 0, 0, 0,  0, O_RUN};
    tbl[4]  = '{31, 31, 1, 0, 0,  31, 1, 1, 0,  0, 0, 0, 0,  0, O_RUN};
    tbl[5]  = '{2,  0,  0, 0, 0,  2,  1, 0, 0,  0, 0, 0, 0,  0, O_RUN};
    tbl[6]  = '{2,  0,  0, 0, 0,  2,  0, 1, 0,  0, 0, 0, 0,  0, O_RUN};
    tbl[7]  = '{0,  0,  0, 5, 6,  0,  0, 0, 5,  1, 0, 0, 5,  1, 11'b11_0_000_0_10_00};
    tbl[8]  = '{0,  0,  0, 5, 6,  0,  0, 0, 5,  1, 1, 0, 5,  1, 11'b11_0_000_0_01_00};
    tbl[9]  = '{0,  0,  0, 5, 5,  0,  0, 0, 5,  1, 0, 0, 5,  1, 11'b11_0_000_0_10_10};
    tbl[10] = '{0,  0,  0, 7, 31, 0,  0, 0, 31, 1, 0, 0, 31, 1, O_RUN};
    tbl[11] = '{0,  0,  0, 1, 9,  0,  0, 0, 9,  0, 0, 0, 9,  1, 11'b11_0_000_0_00_01};
    tbl[12] = '{2,  0,  0, 0, 0,  2,  1, 1, 0,  0, 0, 1, 0,  0, O_BR};
    tbl[13] = '{0,  0,  0, 4, 0,  0,  0, 0, 4,  1, 0, 1, 0,  0, 11'b11_0_111_1_10_00};

    // Reset with forwarding and hazard conditions present on the inputs.
    clear_in();
    hazard();
    ex_rn = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1;
    do_reset("rst0");

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(o1), 32'(tbl[i].exp));
      tick();
    end
    clear_in();
    #2;
    chk("tbl_stall_cnt_s1", stall_count1, 32'd2);
    chk("tbl_flush_cnt_s1", flush_count1, 32'd2);

    // Load-use stall: one cycle on u_s1, three cycles on u_s3.
    do_reset("rst1");
    hazard();
    #2;
    chk("ld_use_c1_s1", 32'(o1), 32'(O_STALL));
    chk("ld_use_c1_s3", 32'(o3), 32'(O_STALL));
    tick();
    clear_in();
    #2;
    chk("ld_use_c2_s1", 32'(o1), 32'(O_RUN));
    chk("ld_use_c2_s3", 32'(o3), 32'(O_STALL));
    tick();
    #2;
    chk("ld_use_c3_s3", 32'(o3), 32'(O_STALL));
    tick();
    #2;
    chk("ld_use_c4_s3", 32'(o3), 32'(O_RUN));
    chk("ld_use_stall_cnt_s1", stall_count1, 32'd1);
    chk("ld_use_stall_cnt_s3", 32'(stall_count3), 32'd3);

    // Taken branch in the second cycle of a three-cycle stall.
    do_reset("rst2");
    hazard();
    #2;
    chk("br_stall_c1", 32'(o3), 32'(O_STALL));
    tick();
    clear_in();
    mem_branch_taken = 1'b1;
    #2;
    chk("br_stall_c2", 32'(o3), 32'(O_BR));
    tick();
    mem_branch_taken = 1'b0;
    #2;
    chk("br_stall_c3", 32'(o3), 32'(O_RUN));
    tick();
    #2;
    chk("br_stall_c4", 32'(o3), 32'(O_RUN));
    chk("br_stall_cnt", 32'(stall_count3), 32'd1);
    chk("br_flush_cnt", 32'(flush_count3), 32'd1);

    // Saturation: 18 stall cycles and 17 flushes on the 4-bit counters.
    do_reset("rst3");
    for (int h = 0; h < 6; h++) begin
      hazard();
      tick();
      clear_in();
      tick();
      tick();
    end
    #2;
    chk("sat_stall_cnt_s3", 32'(stall_count3), 32'd15);
    chk("sat_stall_cnt_s1", stall_count1, 32'd6);
    mem_branch_taken = 1'b1;
    repeat (17) tick();
    mem_branch_taken = 1'b0;
    #2;
    chk("sat_flush_cnt_s3", 32'(flush_count3), 32'd15);
    chk("sat_flush_cnt_s1", flush_count1, 32'd17);

    // Reset arriving in the middle of a stall.
    hazard();
    tick();
    clear_in();
    #2;
    chk("mid_stall_pre_rst", 32'(o3), 32'(O_STALL));
    do_reset("rst4");
    #2;
    chk("post_rst_c1", 32'(o3), 32'(O_RUN));
    tick();
    #2;
    chk("post_rst_c2", 32'(o3), 32'(O_RUN));
    chk("post_rst_stall_cnt", 32'(stall_count3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
